// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : shared state encoding, brick-grid constants and score helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

   localparam int GRID_COLS  = 14;
   localparam int GRID_ROWS  = 4;
   localparam int NUM_BLOCKS = GRID_COLS * GRID_ROWS;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SERVE       = 3'd1,
      ST_PLAY        = 3'd2,
      ST_PAUSE       = 3'd3,
      ST_LEVEL_CLEAR = 3'd4,
      ST_GAME_OVER   = 3'd5
   } state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider : modulo-DIV counter with enable/hold/clear, combinational tc
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;

   // Dropping en_i holds the count, which is how a paused game keeps its phase.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   assign tc_o = en_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer : brick-breaker game-flow controller (bricks, lives, score)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_sequencer
   import game_pkg::*;
#(
   parameter int          NUM_BLOCKS   = game_pkg::NUM_BLOCKS,
   parameter int          TICK_DIV     = 750000,
   parameter int          SERVE_CYCLES = 25000000,
   parameter logic [3:0]  INIT_LIVES   = 4'd9,
   parameter logic [15:0] POINTS       = 16'd1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_pulse_i,
   input  logic                  pause_pulse_i,
   input  logic                  hit_valid_i,
   input  logic [5:0]            hit_idx_i,
   input  logic                  ball_miss_i,
   output logic                  move_tick_o,
   output logic                  ball_reset_o,
   output logic [NUM_BLOCKS-1:0] visible_o,
   output logic [3:0]            lives_o,
   output logic [15:0]           score_o,
   output logic [2:0]            state_o,
   output logic                  game_over_o
);

   localparam logic [NUM_BLOCKS-1:0] ALL_BRICKS = '1;

   state_t                state_q, state_d;
   logic [NUM_BLOCKS-1:0] visible_q, visible_d, hit_mask, vis_after;
   logic [3:0]            lives_q, lives_d;
   logic [15:0]           score_q, score_d;
   logic                  move_tick_q, ball_reset_q, game_over_q;
   logic                  hit_ok, serve_tc, tick_tc;
   logic                  entering_serve, tick_en, tick_clr;

   assign hit_mask  = NUM_BLOCKS'(1) << hit_idx_i;
   assign hit_ok    = hit_valid_i && (32'(hit_idx_i) < NUM_BLOCKS) && (|(visible_q & hit_mask));
   assign vis_after = visible_q & ~hit_mask;

   always_comb begin
      state_d   = state_q;
      visible_d = visible_q;
      lives_d   = lives_q;
      score_d   = score_q;
      case (state_q)
         ST_IDLE:  if (start_pulse_i) state_d = ST_SERVE;
         ST_SERVE: if (serve_tc)      state_d = ST_PLAY;
         ST_PLAY: begin
            if (hit_ok) begin
               visible_d = vis_after;
               score_d   = sat_add16(score_q, POINTS);
            end
            // Clearing the last brick outranks a simultaneous miss.
            if (hit_ok && (vis_after == '0)) begin
               state_d = ST_LEVEL_CLEAR;
            end else if (ball_miss_i && (lives_q != 4'd0)) begin
               lives_d = lives_q - 4'd1;
               state_d = (lives_q == 4'd1) ? ST_GAME_OVER : ST_SERVE;
            end else if (pause_pulse_i) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: if (pause_pulse_i) state_d = ST_PLAY;
         ST_LEVEL_CLEAR: begin
            if (start_pulse_i) begin
               visible_d = ALL_BRICKS;
               state_d   = ST_SERVE;
            end
         end
         ST_GAME_OVER: begin
            if (start_pulse_i) begin
               visible_d = ALL_BRICKS;
               lives_d   = INIT_LIVES;
               score_d   = '0;
               state_d   = ST_SERVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign entering_serve = (state_d == ST_SERVE) && (state_q != ST_SERVE);
   // Gating on the next state suppresses a tick in any cycle that leaves PLAY.
   assign tick_en        = (state_q == ST_PLAY) && (state_d == ST_PLAY);
   assign tick_clr       = (state_q == ST_SERVE) && (state_d == ST_PLAY);

   tick_divider #(.DIV(SERVE_CYCLES)) u_serve_timer (
      .clk   (clk),
      .rst   (rst),
      .en_i  (state_q == ST_SERVE),
      .clr_i (entering_serve),
      .tc_o  (serve_tc)
   );

   tick_divider #(.DIV(TICK_DIV)) u_move_timer (
      .clk   (clk),
      .rst   (rst),
      .en_i  (tick_en),
      .clr_i (tick_clr),
      .tc_o  (tick_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         visible_q    <= ALL_BRICKS;
         lives_q      <= INIT_LIVES;
         score_q      <= '0;
         move_tick_q  <= 1'b0;
         ball_reset_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         visible_q    <= visible_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         move_tick_q  <= tick_tc;
         ball_reset_q <= entering_serve;
         game_over_q  <= (state_d == ST_GAME_OVER);
      end
   end

   assign move_tick_o  = move_tick_q;
   assign ball_reset_o = ball_reset_q;
   assign visible_o    = visible_q;
   assign lives_o      = lives_q;
   assign score_o      = score_q;
   assign state_o      = state_q;
   assign game_over_o  = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer : directed scoreboard bench for game_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_sequencer;
   import game_pkg::*;

   localparam int NB = 56;

   localparam int K_STATE = 0;
   localparam int K_LIVES = 1;
   localparam int K_SCORE = 2;
   localparam int K_VIS   = 3;
   localparam int K_TICK  = 4;
   localparam int K_BRST  = 5;
   localparam int K_GO    = 6;
   localparam int K_SAT   = 7;

   logic          clk;
   logic          rst;
   logic          start_pulse, pause_pulse, hit_valid, ball_miss;
   logic [5:0]    hit_idx;
   logic          move_tick, ball_reset, game_over;
   logic [NB-1:0] visible;
   logic [3:0]    lives;
   logic [15:0]   score;
   logic [2:0]    state;
   logic          s_move_tick, s_ball_reset, s_game_over;
   logic [NB-1:0] s_visible;
   logic [3:0]    s_lives;
   logic [15:0]   s_score;
   logic [2:0]    s_state;

   game_sequencer #(.NUM_BLOCKS(NB), .TICK_DIV(4), .SERVE_CYCLES(8),
                    .INIT_LIVES(4'd3), .POINTS(16'd1)) dut (
      .clk(clk), .rst(rst), .start_pulse_i(start_pulse), .pause_pulse_i(pause_pulse),
      .hit_valid_i(hit_valid), .hit_idx_i(hit_idx), .ball_miss_i(ball_miss),
      .move_tick_o(move_tick), .ball_reset_o(ball_reset), .visible_o(visible),
      .lives_o(lives), .score_o(score), .state_o(state), .game_over_o(game_over)
   );

   // Second instance with a large score step so saturation is reached quickly.
   game_sequencer #(.NUM_BLOCKS(NB), .TICK_DIV(4), .SERVE_CYCLES(8),
                    .INIT_LIVES(4'd3), .POINTS(16'h8000)) dut_sat (
      .clk(clk), .rst(rst), .start_pulse_i(start_pulse), .pause_pulse_i(pause_pulse),
      .hit_valid_i(hit_valid), .hit_idx_i(hit_idx), .ball_miss_i(ball_miss),
      .move_tick_o(s_move_tick), .ball_reset_o(s_ball_reset), .visible_o(s_visible),
      .lives_o(s_lives), .score_o(s_score), .state_o(s_state), .game_over_o(s_game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] val;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [NB-1:0] vis_m;
   int            score_m, sat_m, lives_m;

   function automatic int model_add(input int a, input int b);
      return (a + b > 65535) ? 65535 : a + b;
   endfunction

   function automatic logic [63:0] observe(input int sel);
      case (sel)
         K_STATE: return 64'(state);
         K_LIVES: return 64'(lives);
         K_SCORE: return 64'(score);
         K_VIS:   return 64'(visible);
         K_TICK:  return 64'(move_tick);
         K_BRST:  return 64'(ball_reset);
         K_GO:    return 64'(game_over);
         K_SAT:   return 64'(s_score);
         default: return '1;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [63:0] val);
      exp_t e;
      e.tag = tag; e.sel = sel; e.val = val;
      sbq.push_back(e);
   endtask

   task automatic push_model(input string tag);
      push({tag, "_lives"}, K_LIVES, 64'(lives_m));
      push({tag, "_score"}, K_SCORE, 64'(score_m));
      push({tag, "_vis"},   K_VIS,   64'(vis_m));
      push({tag, "_sat"},   K_SAT,   64'(sat_m));
   endtask

   task automatic drain();
      exp_t        e;
      logic [63:0] obs;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic serve_phase(input string tag);
      for (int k = 1; k < 8; k++) begin
         push({tag, "_serve_state"}, K_STATE, 64'(ST_SERVE));
         push({tag, "_serve_tick"},  K_TICK,  64'd0);
         push({tag, "_serve_brst"},  K_BRST,  64'd0);
         step();
      end
      push({tag, "_play_entry"},      K_STATE, 64'(ST_PLAY));
      push({tag, "_play_entry_tick"}, K_TICK,  64'd0);
      step();
   endtask

   task automatic hit_brick(input string tag, input int idx);
      hit_valid = 1'b1;
      hit_idx   = 6'(idx);
      if (idx < NB && vis_m[idx]) begin
         vis_m[idx] = 1'b0;
         score_m    = model_add(score_m, 1);
         sat_m      = model_add(sat_m, 32768);
      end
      push_model(tag);
      step();
      hit_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start_pulse = 1'b0; pause_pulse = 1'b0;
      hit_valid = 1'b0; hit_idx = 6'd0; ball_miss = 1'b0;
      vis_m = '1; score_m = 0; sat_m = 0; lives_m = 3;

      step();
      push("rst_state", K_STATE, 64'(ST_IDLE));
      push("rst_tick",  K_TICK,  64'd0);
      push("rst_brst",  K_BRST,  64'd0);
      push("rst_go",    K_GO,    64'd0);
      push_model("rst");
      step();
      rst = 1'b0;

      // IDLE ignores hits and misses
      hit_valid = 1'b1; ball_miss = 1'b1;
      push("idle_hold", K_STATE, 64'(ST_IDLE));
      push_model("idle");
      step();
      hit_valid = 1'b0; ball_miss = 1'b0;

      start_pulse = 1'b1;
      push("start_state", K_STATE, 64'(ST_SERVE));
      push("start_brst",  K_BRST,  64'd1);
      step();
      start_pulse = 1'b0;
      serve_phase("g1");

      for (int k = 1; k <= 8; k++) begin
         push("tick_period", K_TICK, 64'((k % 4) == 0));
         step();
      end

      hit_brick("hit5", 5);
      hit_brick("hit5_again", 5);
      hit_brick("hit60", 60);

      for (int m = 0; m < 2; m++) begin
         ball_miss = 1'b1;
         lives_m--;
         push("miss_state", K_STATE, 64'(ST_SERVE));
         push("miss_brst",  K_BRST,  64'd1);
         push("miss_tick",  K_TICK,  64'd0);
         push_model("miss");
         step();
         ball_miss = 1'b0;
         serve_phase("miss");
      end
      ball_miss = 1'b1;
      lives_m = 0;
      push("last_miss_state", K_STATE, 64'(ST_GAME_OVER));
      push("last_miss_go",    K_GO,    64'd1);
      push("last_miss_brst",  K_BRST,  64'd0);
      push_model("last_miss");
      step();
      push("go_miss_hold", K_STATE, 64'(ST_GAME_OVER));
      push("go_no_underflow", K_LIVES, 64'd0);
      step();
      ball_miss = 1'b0;
      pause_pulse = 1'b1;
      push("go_pause_ignored", K_STATE, 64'(ST_GAME_OVER));
      step();

      // start wins over a simultaneous pause
      start_pulse = 1'b1;
      vis_m = '1; lives_m = 3; score_m = 0; sat_m = 0;
      push("restart_state", K_STATE, 64'(ST_SERVE));
      push("restart_brst",  K_BRST,  64'd1);
      push("restart_go",    K_GO,    64'd0);
      push_model("restart");
      step();
      start_pulse = 1'b0; pause_pulse = 1'b0;
      serve_phase("g2");

      for (int i = 0; i < 55; i++) hit_brick("clear", i);
      ball_miss = 1'b1;
      hit_brick("last_brick", 55);
      ball_miss = 1'b0;
      push("lc_score", K_SCORE, 64'd56);
      push("lc_state", K_STATE, 64'(ST_LEVEL_CLEAR));
      drain();
      pause_pulse = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push("lc_state_hold", K_STATE, 64'(ST_LEVEL_CLEAR));
         push("lc_no_tick",    K_TICK,  64'd0);
         step();
         pause_pulse = 1'b0;
      end
      start_pulse = 1'b1;
      vis_m = '1;
      push("lc_start_state", K_STATE, 64'(ST_SERVE));
      push("lc_start_brst",  K_BRST,  64'd1);
      push_model("lc_start");
      step();
      start_pulse = 1'b0;
      serve_phase("g3");

      step();
      step();
      pause_pulse = 1'b1;
      push("pause_state", K_STATE, 64'(ST_PAUSE));
      push("pause_tick",  K_TICK,  64'd0);
      step();
      pause_pulse = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k == 3) begin
            hit_valid = 1'b1; hit_idx = 6'd0; ball_miss = 1'b1;
         end
         push("paused_state", K_STATE, 64'(ST_PAUSE));
         push("paused_tick",  K_TICK,  64'd0);
         push_model("paused");
         step();
         hit_valid = 1'b0; ball_miss = 1'b0;
      end
      pause_pulse = 1'b1;
      push("resume_state", K_STATE, 64'(ST_PLAY));
      push("resume_tick0", K_TICK,  64'd0);
      step();
      pause_pulse = 1'b0;
      push("resume_tick1", K_TICK, 64'd0);
      step();
      push("resume_tick2", K_TICK, 64'd1);
      step();

      rst = 1'b1;
      vis_m = '1; score_m = 0; sat_m = 0; lives_m = 3;
      push("midrst_state", K_STATE, 64'(ST_IDLE));
      push("midrst_tick",  K_TICK,  64'd0);
      push_model("midrst");
      step();
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the brick-breaker datapath. It owns the brick visibility vector, lives and score, and generates the ball-movement tick. It sequences the ball engine through serve, play, pause, life-lost, level-clear and game-over phases. The ball physics block reports brick hits and misses; this block decides what they mean and when the ball may move.

Parameters:
NUM_BLOCKS, 56, number of bricks (14 x 4); width of visible vector
TICK_DIV, 750000, clk cycles per ball-movement step
SERVE_CYCLES, 25000000, clk cycles ball is held at serve position before play
INIT_LIVES, 9, lives loaded at new game (1..15)
POINTS, 1, score added per brick cleared

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_pulse  in  1  one-cycle debounced start/continue button
pause_pulse  in  1  one-cycle debounced pause toggle
hit_valid  in  1  ball engine reports a brick contact this cycle
hit_idx  in  6  index of contacted brick
ball_miss  in  1  one-cycle pulse: ball passed below paddle
move_tick  out  1  one-cycle enable for ball position update
ball_reset  out  1  one-cycle pulse: reload ball to serve position
visible  out  NUM_BLOCKS  brick present mask, bit i = brick i
lives  out  4  remaining lives
score  out  16  saturating score
state  out  3  current state encoding (for display)
game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset: state=IDLE, visible=all ones, lives=INIT_LIVES, score=0, move_tick=0, ball_reset=0, both counters=0. Reset mid-operation aborts any state the same cycle.
- All outputs registered; input event in cycle N is visible on outputs in cycle N+1.
- States: IDLE, SERVE, PLAY, PAUSE, LEVEL_CLEAR, GAME_OVER.
- IDLE: holds. start_pulse -> SERVE.
- SERVE entry: ball_reset high for exactly one cycle (the first SERVE cycle). Serve counter counts 0..SERVE_CYCLES-1; at terminal count -> PLAY. No move_tick in SERVE. hit_valid/ball_miss ignored.
- PLAY: tick counter counts 0..TICK_DIV-1 and wraps. move_tick=1 in the cycle after the counter reaches TICK_DIV-1. Counter clears on entry to PLAY from SERVE; holds its value across PAUSE.
- Brick hit in PLAY: if hit_valid, hit_idx<NUM_BLOCKS and visible[hit_idx]=1, then clear that bit and add POINTS to score, saturating at 16'hFFFF. A hit on a cleared bit or on idx>=NUM_BLOCKS is ignored, with no score change.
- Miss in PLAY: lives decremented. If the result is 0 -> GAME_OVER; else -> SERVE (ball_reset pulses).
- Simultaneous hit and miss: apply hit first. If that hit clears the last brick, go to LEVEL_CLEAR and lose no life. Otherwise process the miss.
- All bricks cleared (visible becomes 0) -> LEVEL_CLEAR. move_tick suppressed from that cycle.
- pause_pulse in PLAY -> PAUSE; in PAUSE -> PLAY. Ignored in all other states. In PAUSE, no ticks and hit/miss are ignored.
- LEVEL_CLEAR: start_pulse reloads visible to all ones and goes to SERVE. Score and lives are kept.
- GAME_OVER: game_over=1. start_pulse reloads visible, lives and score (score=0) and goes to SERVE.
- If start_pulse and pause_pulse arrive together, the start-driven transition wins where start is valid.
- lives never underflows; a miss is only honoured when lives>0.

Decomposition:
- Shared package game_pkg: state enum encoding (IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LEVEL_CLEAR=4, GAME_OVER=5), NUM_BLOCKS, grid constants (14, 4).
- One sub-module: tick_divider (parameterised modulo counter with enable, hold and clear, terminal-count pulse). It is instantiated twice, once for the serve timer and once for the move tick.

Test Plan:
Run all scenarios with TICK_DIV=4, SERVE_CYCLES=8, INIT_LIVES=3.
- Reset then start_pulse -> ball_reset is a single pulse at the first SERVE cycle; PLAY is entered 8 cycles later; move_tick pulses every 4 cycles; visible=all ones, lives=3, score=0.
- In PLAY, hit_idx=5, then hit_idx=5 again, then hit_idx=60 -> visible[5]=0 one cycle after the first hit; score=1 and unchanged afterward.
- Three ball_miss pulses, each separated by a full serve -> lives goes 2, then 1, then 0. GAME_OVER follows the third miss and game_over=1. A later start_pulse restores lives=3, score=0, visible=all ones, and a ball_reset pulse occurs.
- Clear 55 bricks, then hit the last brick with ball_miss in the same cycle -> LEVEL_CLEAR, lives unchanged, score=56, no move_tick. A following start_pulse refills visible while keeping score=56.
- pause_pulse with the tick counter at 2 -> no move_tick during 20 cycles; a hit and a miss applied while paused are ignored. A second pause_pulse resumes PLAY and move_tick arrives 2 cycles later.
- Score preloaded near 16'hFFFF via repeated level clears (or POINTS=16'h8000) -> score saturates at 16'hFFFF.
